layer_controller: RTL and testbench

Sequencer for one fully-connected perceptron layer. It accepts an input vector over a valid/ready handshake, latches it, and steps the shared term index across the bias and input slots while driving MAC clear/enable to the parallel perceptron array. It then waits out the MAC pipeline latency, captures all neuron results, and presents them downstream with valid/ready backpressure. It replaces the free-running index counter so that layers can be chained frame by frame.

---
 rtl/layer_controller.sv | 156 +++++++++++++++
 tb/tb_layer_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_controller.sv
// Sequences one fully-connected layer: latch a frame, step bias+input terms into the MAC array, drain, present results.
// Latency: accept edge T -> out_valid at T+N_TERMS+MAC_LAT+1; min frame period N_TERMS+MAC_LAT+2 cycles.
// Backpressure: in_ready only in IDLE; out_ready low in DONE holds out_valid/out_data indefinitely.
module layer_controller #(
    parameter int N_IN    = 4,
    parameter int N_OUT   = 4,
    parameter int DW      = 32,
    parameter int MAC_LAT = 3,
    parameter int IDX_W   = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*DW-1:0]    in_data,
    input  logic                  act_sel_in,
    output logic [IDX_W-1:0]      index,
    output logic [DW-1:0]         x_out,
    output logic                  act_sel,
    output logic                  mac_clr,
    output logic                  mac_en,
    input  logic [N_OUT*DW-1:0]   mac_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT*DW-1:0]   out_data,
    output logic                  busy
);
    localparam int N_TERMS = N_IN + 1;
    localparam int CNT_W   = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_TERMS - 1);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(MAC_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     index_nxt;
    logic [DW-1:0]        x_nxt;
    logic                 clr_nxt;
    logic                 en_nxt;
    logic                 vld_nxt;
    logic                 accept;
    logic                 capture;
    logic [N_IN*DW-1:0]   in_buf;

    // Ready is decoded from state and suppressed while reset is held.
    assign in_ready = (state_q == IDLE) && !rstn;

    // Next-state and next values of the registered control outputs; x_out is
    // precomputed for the index being entered so both change on the same edge.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        index_nxt = '0;
        x_nxt     = '0;
        clr_nxt   = 1'b0;
        en_nxt    = 1'b0;
        vld_nxt   = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                    en_nxt    = 1'b1;
                    clr_nxt   = 1'b1;
                end
            end
            RUN: begin
                if (index == LAST_IDX) begin
                    state_nxt = DRAIN;
                    cnt_nxt   = DRAIN_INIT;
                end else begin
                    index_nxt = index + 1'b1;
                    en_nxt    = 1'b1;
                    // Term index+1 carries input element index.
                    for (int k = 0; k < N_IN; k++) begin
                        if (index == IDX_W'(k)) begin
                            x_nxt = in_buf[k*DW +: DW];
                        end
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                    vld_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end else begin
                    vld_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered control outputs; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            index     <= '0;
            x_out     <= '0;
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            act_sel   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            index     <= index_nxt;
            x_out     <= x_nxt;
            mac_clr   <= clr_nxt;
            mac_en    <= en_nxt;
            out_valid <= vld_nxt;
            busy      <= (state_nxt != IDLE);
            if (accept) begin
                act_sel <= act_sel_in;
            end
        end
    end

    // Result register: sampled once on the last drain cycle, then held through DONE.
    always_ff @(posedge clk) begin
        if (rstn) begin
            out_data <= '0;
        end else if (capture) begin
            out_data <= mac_result;
        end
    end

    // Input vector buffer: only read while in RUN, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            in_buf <= in_data;
        end
    end
endmodule

// File: tb/tb_layer_controller.sv
module tb_layer_controller;
    localparam int N_IN    = 4;
    localparam int N_OUT   = 4;
    localparam int DW      = 32;
    localparam int MAC_LAT = 3;
    localparam int IDX_W   = 3;
    localparam int N_TERMS = N_IN + 1;

    typedef struct packed {
        logic             in_ready;
        logic [IDX_W-1:0] index;
        logic [DW-1:0]    x_out;
        logic             act_sel;
        logic             mac_clr;
        logic             mac_en;
        logic             out_valid;
        logic             busy;
    } obs_t;

    logic                clk;
    logic                rstn;
    logic                in_valid;
    logic                in_valid_b;
    logic [N_IN*DW-1:0]  in_data;
    logic                act_sel_in;
    logic                out_ready;
    logic [N_OUT*DW-1:0] mac_result;

    logic                in_ready,  in_ready_b;
    logic [IDX_W-1:0]    index,     index_b;
    logic [DW-1:0]       x_out,     x_out_b;
    logic                act_sel,   act_sel_b;
    logic                mac_clr,   mac_clr_b;
    logic                mac_en,    mac_en_b;
    logic                out_valid, out_valid_b;
    logic [N_OUT*DW-1:0] out_data,  out_data_b;
    logic                busy,      busy_b;

    int n_checks = 0;
    int n_pass   = 0;
    logic [N_OUT*DW-1:0] mac_log[$];

    layer_controller #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .MAC_LAT(MAC_LAT), .IDX_W(IDX_W)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .act_sel_in(act_sel_in), .index(index), .x_out(x_out), .act_sel(act_sel),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_result(mac_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    layer_controller #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .MAC_LAT(1), .IDX_W(IDX_W)) u_dut_lat1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .act_sel_in(act_sel_in), .index(index_b), .x_out(x_out_b), .act_sel(act_sel_b),
        .mac_clr(mac_clr_b), .mac_en(mac_en_b), .mac_result(mac_result), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record the mac_result value present at every rising edge.
    always @(posedge clk) mac_log.push_back(mac_result);

    // Perceptron array stand-in: a fresh random result every cycle, well away from the edge.
    initial mac_result = '0;
    always @(posedge clk) begin
        #2;
        mac_result = {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic obs_t grab_a();
        obs_t o;
        o.in_ready = in_ready; o.index = index; o.x_out = x_out; o.act_sel = act_sel;
        o.mac_clr = mac_clr; o.mac_en = mac_en; o.out_valid = out_valid; o.busy = busy;
        return o;
    endfunction

    function automatic obs_t grab_b();
        obs_t o;
        o.in_ready = in_ready_b; o.index = index_b; o.x_out = x_out_b; o.act_sel = act_sel_b;
        o.mac_clr = mac_clr_b; o.mac_en = mac_en_b; o.out_valid = out_valid_b; o.busy = busy_b;
        return o;
    endfunction

    // Reference: expected outputs t cycles after the accepting edge of a frame.
    // Terms occupy t=1..N_TERMS, drain the next lat cycles, results thereafter.
    function automatic obs_t model(int t, logic [N_IN*DW-1:0] d, logic a, int lat);
        obs_t o;
        o = '0;
        o.act_sel = a;
        o.busy    = 1'b1;
        if (t <= N_TERMS) begin
            o.index   = IDX_W'(t - 1);
            o.mac_en  = 1'b1;
            o.mac_clr = (t == 1);
            if (t > 1) o.x_out = d[(t-2)*DW +: DW];
        end else if (t > N_TERMS + lat) begin
            o.out_valid = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t idle_model(logic a);
        obs_t o;
        o = '0;
        o.in_ready = 1'b1;
        o.act_sel  = a;
        return o;
    endfunction

    function automatic logic [N_IN*DW-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [N_OUT*DW-1:0] last_mac();
        return mac_log[mac_log.size()-1];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t exp, obs;
        rstn = 1'b1; in_valid = 1'b0; in_valid_b = 1'b0; out_ready = 1'b0;
        in_data = '0; act_sel_in = 1'b0;
        repeat (3) step();
        exp = '0;
        obs = grab_a();
        n_checks++;
        if (obs !== exp) $display("FAIL reset_outputs got=%h want=%h", obs, exp); else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL reset_out_data got=%h want=0", out_data); else n_pass++;
        obs = grab_b();
        n_checks++;
        if (obs !== exp) $display("FAIL reset_outputs_lat1 got=%h want=%h", obs, exp); else n_pass++;
        rstn = 1'b0;
        step();
        exp = idle_model(1'b0);
        obs = grab_a();
        n_checks++;
        if (obs !== exp) $display("FAIL reset_release got=%h want=%h", obs, exp); else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [N_IN*DW-1:0] d;
        obs_t exp, obs;
        d = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        out_ready = 1'b1; in_data = d; act_sel_in = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = '0; act_sel_in = 1'b0;
        for (int t = 1; t <= N_TERMS + MAC_LAT + 1; t++) begin
            exp = model(t, d, 1'b1, MAC_LAT);
            obs = grab_a();
            n_checks++;
            if (obs !== exp) $display("FAIL single_trace t=%0d got=%h want=%h", t, obs, exp); else n_pass++;
            if (t == N_TERMS + MAC_LAT + 1) begin
                n_checks++;
                if (out_data !== last_mac()) $display("FAIL single_out_data got=%h want=%h", out_data, last_mac());
                else n_pass++;
            end
            step();
        end
        exp = idle_model(1'b1);
        obs = grab_a();
        n_checks++;
        if (obs !== exp) $display("FAIL single_idle got=%h want=%h", obs, exp); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [N_IN*DW-1:0] d;
        logic [N_OUT*DW-1:0] held;
        logic a;
        obs_t exp, obs;
        d = rand_vec(); a = 1'($urandom_range(0, 1));
        out_ready = 1'b0; in_data = d; act_sel_in = a; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int t = 1; t <= N_TERMS + MAC_LAT + 1; t++) begin
            exp = model(t, d, a, MAC_LAT);
            obs = grab_a();
            n_checks++;
            if (obs !== exp) $display("FAIL bp_trace t=%0d got=%h want=%h", t, obs, exp); else n_pass++;
            if (t < N_TERMS + MAC_LAT + 1) step();
        end
        held = last_mac();
        n_checks++;
        if (out_data !== held) $display("FAIL bp_capture got=%h want=%h", out_data, held); else n_pass++;
        exp = model(N_TERMS + MAC_LAT + 1, d, a, MAC_LAT);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = rand_vec();
            step();
            obs = grab_a();
            n_checks++;
            if (obs !== exp || out_data !== held)
                $display("FAIL bp_stall i=%0d got=%h/%h want=%h/%h", i, obs, out_data, exp, held);
            else n_pass++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        exp = idle_model(a);
        obs = grab_a();
        n_checks++;
        if (obs !== exp) $display("FAIL bp_release got=%h want=%h", obs, exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [N_IN*DW-1:0] f[3];
        logic a[3];
        int pulses;
        obs_t exp, obs;
        for (int i = 0; i < 3; i++) begin
            f[i] = rand_vec();
            a[i] = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1; in_data = f[0]; act_sel_in = a[0]; in_valid = 1'b1;
        step();
        pulses = 0;
        for (int c = 1; c <= 30; c++) begin
            int k, t;
            k = (c - 1) / 10;
            t = c - 10 * k;
            if (t == 1) begin
                if (k < 2) begin
                    in_data = f[k+1]; act_sel_in = a[k+1];
                end else begin
                    in_valid = 1'b0;
                end
            end
            exp = (t <= N_TERMS + MAC_LAT + 1) ? model(t, f[k], a[k], MAC_LAT) : idle_model(a[k]);
            obs = grab_a();
            n_checks++;
            if (obs !== exp) $display("FAIL b2b_trace frame=%0d t=%0d got=%h want=%h", k, t, obs, exp); else n_pass++;
            if (t == N_TERMS + MAC_LAT + 1) begin
                n_checks++;
                if (out_data !== last_mac()) $display("FAIL b2b_out_data frame=%0d got=%h want=%h", k, out_data, last_mac());
                else n_pass++;
            end
            if (out_valid) pulses++;
            step();
        end
        n_checks++;
        if (pulses !== 3) $display("FAIL b2b_pulses got=%0d want=3", pulses); else n_pass++;
    endtask

    task automatic test_ignore_inputs();
        logic [N_IN*DW-1:0] d;
        logic a;
        obs_t exp, obs;
        for (int r = 0; r < 3; r++) begin
            d = rand_vec(); a = 1'($urandom_range(0, 1));
            out_ready = 1'b1; in_data = d; act_sel_in = a; in_valid = 1'b1;
            step();
            for (int t = 1; t <= N_TERMS + MAC_LAT + 1; t++) begin
                in_valid = (t < N_TERMS + MAC_LAT + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_data = rand_vec();
                act_sel_in = ~a;
                exp = model(t, d, a, MAC_LAT);
                obs = grab_a();
                n_checks++;
                if (obs !== exp) $display("FAIL ignore_trace r=%0d t=%0d got=%h want=%h", r, t, obs, exp); else n_pass++;
                step();
            end
            exp = idle_model(a);
            obs = grab_a();
            n_checks++;
            if (obs !== exp) $display("FAIL ignore_idle r=%0d got=%h want=%h", r, obs, exp); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic [N_IN*DW-1:0] d;
        logic a;
        obs_t exp, obs;
        d = rand_vec(); a = 1'b1;
        out_ready = 1'b1; in_data = d; act_sel_in = a; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            exp = model(t, d, a, MAC_LAT);
            obs = grab_a();
            n_checks++;
            if (obs !== exp) $display("FAIL midrst_pre t=%0d got=%h want=%h", t, obs, exp); else n_pass++;
            if (t < 3) step();
        end
        rstn = 1'b1;
        step();
        exp = '0;
        obs = grab_a();
        n_checks++;
        if (obs !== exp) $display("FAIL midrst_abort got=%h want=%h", obs, exp); else n_pass++;
        n_checks++;
        if (out_data !== '0) $display("FAIL midrst_out_data got=%h want=0", out_data); else n_pass++;
        rstn = 1'b0;
        d = rand_vec(); a = 1'($urandom_range(0, 1));
        in_data = d; act_sel_in = a; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int t = 1; t <= N_TERMS + MAC_LAT + 1; t++) begin
            exp = model(t, d, a, MAC_LAT);
            obs = grab_a();
            n_checks++;
            if (obs !== exp) $display("FAIL midrst_fresh t=%0d got=%h want=%h", t, obs, exp); else n_pass++;
            if (t == N_TERMS + MAC_LAT + 1) begin
                n_checks++;
                if (out_data !== last_mac()) $display("FAIL midrst_fresh_data got=%h want=%h", out_data, last_mac());
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_mac_lat1();
        logic [N_IN*DW-1:0] d;
        logic a;
        obs_t exp, obs;
        d = rand_vec(); a = 1'($urandom_range(0, 1));
        out_ready = 1'b1; in_data = d; act_sel_in = a; in_valid_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        for (int t = 1; t <= N_TERMS + 2; t++) begin
            exp = model(t, d, a, 1);
            obs = grab_b();
            n_checks++;
            if (obs !== exp) $display("FAIL lat1_trace t=%0d got=%h want=%h", t, obs, exp); else n_pass++;
            if (t == N_TERMS + 2) begin
                n_checks++;
                if (out_data_b !== last_mac()) $display("FAIL lat1_out_data got=%h want=%h", out_data_b, last_mac());
                else n_pass++;
            end
            step();
        end
        exp = idle_model(a);
        obs = grab_b();
        n_checks++;
        if (obs !== exp) $display("FAIL lat1_idle got=%h want=%h", obs, exp); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_ignore_inputs();
        test_mid_reset();
        test_mac_lat1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
